// File: rtl/usb_cdc_pkg.sv
// Shared definitions for the USB CDC device blocks: FIFO FSM state encodings
// and the constant-width helper used to size pointers and counters.
package usb_cdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_NAK  = 2'd2
  } out_state_t;

  function automatic int ceil_log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/p17_out_fifo.sv
// OUT endpoint FIFO between the SIE and the application: bytes of a packet are
// written tentatively and only become readable once the packet is ACKed.
module p17_out_fifo
  import usb_cdc_pkg::*;
#(
  parameter int OUT_MAXPACKETSIZE = 8,
  parameter int BIT_SAMPLES       = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  output logic [7:0] app_out_data_o,
  output logic       app_out_valid_o,
  input  logic       app_out_ready_i,
  output logic       out_empty_o,
  output logic       out_full_o,
  output logic       out_nak_o,
  input  logic       out_req_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  input  logic       out_err_i,
  input  logic       out_ready_i
);

  localparam int OUT_LENGTH = 2 * OUT_MAXPACKETSIZE + 1;
  localparam int PTR_W      = ceil_log2(OUT_LENGTH);
  localparam int CNT_W      = (BIT_SAMPLES > 1) ? ceil_log2(BIT_SAMPLES) : 1;

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(OUT_LENGTH - 1);
  localparam logic [PTR_W:0]   LEN_EXT  = (PTR_W+1)'(OUT_LENGTH);
  localparam logic [PTR_W:0]   MPS_EXT  = (PTR_W+1)'(OUT_MAXPACKETSIZE);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BIT_SAMPLES - 1);

  out_state_t       out_state_q;
  logic [7:0]       out_buffer [0:OUT_LENGTH-1];
  logic [PTR_W-1:0] out_first_q;
  logic [PTR_W-1:0] out_last_q;
  logic [PTR_W-1:0] out_last_qq;
  logic             out_overflow_q;
  logic             out_req_q;
  logic [CNT_W-1:0] app_delay_q;

  logic             req_rise;
  logic             req_fall;
  logic             byte_accept;
  logic             overflow_next;
  logic [PTR_W-1:0] last_qq_next;
  logic             buf_write;
  logic             app_read;
  logic [PTR_W:0]   free_space;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_IDX) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Free entries behind the committed pointer; the slot before out_first_q is never used.
  always_comb begin
    free_space = '0;
    if (out_first_q > out_last_q)
      free_space = {1'b0, out_first_q} - {1'b0, out_last_q} - (PTR_W+1)'(1);
    else
      free_space = {1'b0, out_first_q} + LEN_EXT - {1'b0, out_last_q} - (PTR_W+1)'(1);
  end

  assign out_empty_o = (out_first_q == out_last_q);
  assign out_full_o  = (inc_ptr(out_last_qq) == out_first_q);
  assign out_nak_o   = (free_space < MPS_EXT);

  assign req_rise      = out_req_i & ~out_req_q;
  assign req_fall      = ~out_req_i & out_req_q;
  assign byte_accept   = out_valid_i & ~out_full_o;
  assign overflow_next = out_overflow_q | (out_valid_i & out_full_o);
  assign last_qq_next  = byte_accept ? inc_ptr(out_last_qq) : out_last_qq;
  assign buf_write     = (out_state_q == ST_DATA) & byte_accept;

  assign app_out_data_o  = out_buffer[out_first_q];
  assign app_out_valid_o = ~out_empty_o & (app_delay_q == CNT_MAX);
  assign app_read        = app_out_valid_o & app_out_ready_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < OUT_LENGTH; i++) out_buffer[i] <= '0;
    end else if (buf_write) begin
      out_buffer[out_last_qq] <= out_data_i;
    end
  end

  // Packet FSM: the tentative pointer runs ahead and is either committed or rolled back.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_state_q    <= ST_IDLE;
      out_last_q     <= '0;
      out_last_qq    <= '0;
      out_overflow_q <= 1'b0;
      out_req_q      <= 1'b0;
    end else begin
      out_req_q <= out_req_i;
      case (out_state_q)
        ST_IDLE: begin
          if (req_rise) begin
            out_last_qq    <= out_last_q;
            out_overflow_q <= 1'b0;
            out_state_q    <= out_nak_o ? ST_NAK : ST_DATA;
          end
        end
        ST_DATA: begin
          if (out_err_i || (req_fall && !out_ready_i)) begin
            out_last_qq <= out_last_q;
            out_state_q <= ST_IDLE;
          end else if (out_ready_i) begin
            // A byte strobed together with the ACK belongs to the committed packet.
            if (overflow_next) begin
              out_last_qq <= out_last_q;
            end else begin
              out_last_q  <= last_qq_next;
              out_last_qq <= last_qq_next;
            end
            out_state_q <= ST_IDLE;
          end else if (out_valid_i) begin
            out_last_qq    <= last_qq_next;
            out_overflow_q <= overflow_next;
          end
        end
        ST_NAK: begin
          if (req_fall) out_state_q <= ST_IDLE;
        end
        default: out_state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_first_q <= '0;
      app_delay_q <= '0;
    end else if (app_read) begin
      out_first_q <= inc_ptr(out_first_q);
      app_delay_q <= '0;
    end else if (app_delay_q != CNT_MAX) begin
      app_delay_q <= app_delay_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_p17_out_fifo.sv
// Scoreboard bench for p17_out_fifo: the driver predicts which packets land in
// the FIFO, and a monitor pops expected bytes whenever the application accepts one.
module tb_p17_out_fifo;

  localparam int MPS       = 8;
  localparam int BS        = 4;
  localparam int CAPACITY  = 2 * MPS;
  localparam int END_READY = 0;
  localparam int END_ERR   = 1;
  localparam int END_FALL  = 2;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic [7:0] app_out_data_o;
  logic       app_out_valid_o;
  logic       app_out_ready_i;
  logic       out_empty_o;
  logic       out_full_o;
  logic       out_nak_o;
  logic       out_req_i;
  logic [7:0] out_data_i;
  logic       out_valid_i;
  logic       out_err_i;
  logic       out_ready_i;

  int         assert_count = 0;
  int         fail_count   = 0;
  int         cycle_count  = 0;
  int         last_read_cycle = -100;
  int         app_mode = 0;
  logic [7:0] sb_q[$];
  logic [7:0] pkt[$];

  p17_out_fifo #(.OUT_MAXPACKETSIZE(MPS), .BIT_SAMPLES(BS)) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .app_out_data_o(app_out_data_o),
    .app_out_valid_o(app_out_valid_o),
    .app_out_ready_i(app_out_ready_i),
    .out_empty_o(out_empty_o),
    .out_full_o(out_full_o),
    .out_nak_o(out_nak_o),
    .out_req_i(out_req_i),
    .out_data_i(out_data_i),
    .out_valid_i(out_valid_i),
    .out_err_i(out_err_i),
    .out_ready_i(out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycle_count++;

  // Application side: 0 = always ready, 1 = stalled, otherwise randomly ready.
  always @(posedge clk_i) begin
    #1;
    if (app_mode == 0) app_out_ready_i = 1'b1;
    else if (app_mode == 1) app_out_ready_i = 1'b0;
    else app_out_ready_i = ($urandom_range(0, 3) != 0);
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rstn_i) begin
      last_read_cycle = -100;
    end else if (app_out_valid_o) begin
      assert_count++;
      if (sb_q.size() == 0) begin
        fail_count++;
        $display("[TB] FAIL spurious_valid: got valid=1 data=0x%0h expected no stored byte", app_out_data_o);
      end else if (app_out_ready_i) begin
        check_output("read_data", app_out_data_o, sb_q.pop_front());
        assert_count++;
        if (cycle_count - last_read_cycle < BS) begin
          fail_count++;
          $display("[TB] FAIL read_spacing: got %0d cycles expected >= %0d", cycle_count - last_read_cycle, BS);
        end
        last_read_cycle = cycle_count;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_valid"}, app_out_valid_o, 1'b0);
    check_output({tag, "_data"},  app_out_data_o, 8'h00);
    check_output({tag, "_empty"}, out_empty_o, 1'b1);
    check_output({tag, "_full"},  out_full_o, 1'b0);
    check_output({tag, "_nak"},   out_nak_o, 1'b0);
  endtask

  // One SIE OUT transaction; the expected bytes go to the scoreboard only when the
  // model says the packet is accepted, not NAKed, and did not overflow.
  task automatic apply_stimulus(input logic [7:0] bytes[$], input int end_kind, input bit same_cycle);
    logic [7:0] pending[$];
    bit         nak;
    bit         ovf;
    bit         exp_full;
    bit         last;
    step();
    nak = (CAPACITY - sb_q.size()) < MPS;
    check_output("nak_at_request", out_nak_o, nak);
    out_req_i = 1'b1;
    step();
    ovf = 1'b0;
    for (int i = 0; i < bytes.size(); i++) begin
      last = (i == bytes.size() - 1);
      exp_full = ((sb_q.size() + pending.size()) == CAPACITY);
      check_output("full_before_byte", out_full_o, exp_full);
      out_valid_i = 1'b1;
      out_data_i  = bytes[i];
      if (!nak) begin
        if (exp_full) ovf = 1'b1;
        else pending.push_back(bytes[i]);
      end
      if (last && same_cycle && end_kind == END_READY) begin
        out_ready_i = 1'b1;
        if (!nak && !ovf) foreach (pending[j]) sb_q.push_back(pending[j]);
      end
      step();
      out_valid_i = 1'b0;
      out_ready_i = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    if (!(same_cycle && end_kind == END_READY)) begin
      if (end_kind == END_READY) begin
        out_ready_i = 1'b1;
        if (!nak && !ovf) foreach (pending[j]) sb_q.push_back(pending[j]);
      end else if (end_kind == END_ERR) begin
        out_err_i = 1'b1;
      end
      step();
      out_ready_i = 1'b0;
      out_err_i   = 1'b0;
    end
    out_req_i = 1'b0;
    step();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    assert_count++;
    if (sb_q.size() != 0) begin
      fail_count++;
      $display("[TB] FAIL drain_timeout: got %0d bytes outstanding expected 0", sb_q.size());
      sb_q.delete();
    end
    repeat (BS + 2) step();
    check_output("empty_after_drain", out_empty_o, 1'b1);
  endtask

  task automatic random_packet(input int len);
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int kind;
    rstn_i = 1'b0;
    out_req_i = 1'b0;
    out_data_i = 8'h00;
    out_valid_i = 1'b0;
    out_err_i = 1'b0;
    out_ready_i = 1'b0;
    app_mode = 0;
    repeat (3) step();
    check_reset_outputs("reset");
    rstn_i = 1'b1;
    step();

    $display("[TB] basic three-byte packet");
    pkt = {8'h11, 8'h22, 8'h33};
    apply_stimulus(pkt, END_READY, 1'b0);
    drain(200);

    $display("[TB] errored packet then single byte");
    pkt = {8'h01, 8'h02, 8'h03};
    apply_stimulus(pkt, END_ERR, 1'b0);
    repeat (BS + 4) step();
    check_output("empty_after_err", out_empty_o, 1'b1);
    pkt = {8'hAA};
    apply_stimulus(pkt, END_READY, 1'b0);
    drain(200);

    $display("[TB] two full packets with stalled app, third NAKed");
    app_mode = 1;
    random_packet(8);
    apply_stimulus(pkt, END_READY, 1'b0);
    random_packet(8);
    apply_stimulus(pkt, END_READY, 1'b0);
    check_output("nak_when_full", out_nak_o, 1'b1);
    random_packet(8);
    apply_stimulus(pkt, END_READY, 1'b0);
    app_mode = 0;
    drain(500);

    $display("[TB] five packets with concurrent reads across wrap");
    for (int p = 0; p < 5; p++) begin
      random_packet(8);
      apply_stimulus(pkt, END_READY, 1'b0);
      repeat (4) step();
    end
    drain(800);

    $display("[TB] reset in the middle of a packet");
    step();
    out_req_i = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      out_valid_i = 1'b1;
      out_data_i  = 8'hC0 + 8'(i);
      step();
      out_valid_i = 1'b0;
      step();
    end
    #2;
    rstn_i = 1'b0;
    out_req_i = 1'b0;
    #1;
    check_reset_outputs("midreset");
    step();
    rstn_i = 1'b1;
    step();
    pkt = {8'h5A, 8'h6B, 8'h7C, 8'h8D};
    apply_stimulus(pkt, END_READY, 1'b0);
    drain(300);

    $display("[TB] last byte and ACK in the same cycle");
    pkt = {8'h10, 8'h20, 8'h7E};
    apply_stimulus(pkt, END_READY, 1'b1);
    drain(200);

    $display("[TB] request dropped without ACK");
    pkt = {8'hDE, 8'hAD};
    apply_stimulus(pkt, END_FALL, 1'b0);
    pkt = {8'hBE, 8'hEF};
    apply_stimulus(pkt, END_READY, 1'b0);
    drain(200);

    $display("[TB] randomized traffic");
    app_mode = 2;
    for (int p = 0; p < 40; p++) begin
      random_packet($urandom_range(1, 10));
      kind = $urandom_range(0, 9);
      if (kind < 7) apply_stimulus(pkt, END_READY, 1'($urandom_range(0, 1)));
      else if (kind < 9) apply_stimulus(pkt, END_ERR, 1'b0);
      else apply_stimulus(pkt, END_FALL, 1'b0);
      repeat ($urandom_range(0, 6)) step();
    end
    drain(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/p17_out_fifo.md
P17_OUT_FIFO -- requirements
Module: p17_out_fifo

Interface
REQ-001 SHALL have parameter OUT_MAXPACKETSIZE, default 8, max OUT data bytes per packet.
REQ-002 SHALL have parameter BIT_SAMPLES, default 4, clk_i cycles per USB bit; also the minimum spacing between app reads.
REQ-003 SHALL have ports:
- clk_i  in  1  single clock, 12MHz*BIT_SAMPLES.
- rstn_i  in  1  reset; asynchronous, active-low.
- app_out_data_o  out  8  head byte to application.
- app_out_valid_o  out  1  app_out_data_o valid.
- app_out_ready_i  in  1  application accepts byte when high with valid.
- out_empty_o  out  1  no committed bytes stored.
- out_full_o  out  1  no free entry, tentative pointer included.
- out_nak_o  out  1  free space < OUT_MAXPACKETSIZE; SIE shall NAK.
- out_req_i  in  1  high for the duration of an SIE OUT transaction.
- out_data_i  in  8  received byte.
- out_valid_i  in  1  one-cycle strobe, out_data_i valid.
- out_err_i  in  1  one-cycle strobe, packet bad (CRC/PID/bitstuff).
- out_ready_i  in  1  one-cycle strobe, packet ended good, ACK sent.

Function
REQ-004 Storage SHALL be OUT_LENGTH = 2*OUT_MAXPACKETSIZE+1 byte entries, circular; pointers out_first_q (read), out_last_q (committed write), out_last_qq (tentative write), width ceil_log2(OUT_LENGTH).
REQ-005 Pointer increment SHALL wrap from OUT_LENGTH-1 to 0.
REQ-006 out_empty_o SHALL be (out_first_q == out_last_q); out_full_o SHALL be (out_last_qq+1 mod OUT_LENGTH == out_first_q).
REQ-007 out_nak_o SHALL be high when (out_first_q - out_last_q - 1) mod OUT_LENGTH < OUT_MAXPACKETSIZE.
REQ-008 FSM states: ST_IDLE, ST_DATA, ST_NAK.
REQ-009 ST_IDLE: on out_req_i rising edge (registered previous value 0, current 1), go to ST_NAK if out_nak_o, else ST_DATA; out_last_qq <= out_last_q; overflow flag cleared.
REQ-010 ST_DATA: each out_valid_i writes out_data_i at out_last_qq and increments it; if out_full_o, byte is dropped and overflow flag set.
REQ-011 ST_DATA: out_ready_i with overflow clear SHALL set out_last_q <= out_last_qq (commit) and go to ST_IDLE; with overflow set, rollback (out_last_qq <= out_last_q) and go to ST_IDLE.
REQ-012 ST_DATA: out_err_i, or out_req_i falling without out_ready_i, SHALL roll back and go to ST_IDLE.
REQ-013 ST_NAK: out_valid_i, out_ready_i, out_err_i ignored; go to ST_IDLE when out_req_i falls.
REQ-014 Same-cycle out_valid_i and out_ready_i: the byte SHALL be included in the commit.
REQ-015 app_out_data_o SHALL be the entry at out_first_q; app_out_valid_o = ~out_empty_o & (delay counter == BIT_SAMPLES-1).
REQ-016 On app_out_valid_o & app_out_ready_i, out_first_q SHALL increment and the delay counter SHALL clear; the counter saturates at BIT_SAMPLES-1.
REQ-017 A committed byte SHALL be visible on app_out_valid_o no earlier than the cycle after commit.
REQ-018 App read and SIE write/commit in the same cycle SHALL both take effect.

Reset
REQ-019 While rstn_i low: state ST_IDLE, all pointers 0, delay counter 0, overflow 0, storage 0, in-flight packet discarded.
REQ-020 Output values in reset: app_out_valid_o 0, app_out_data_o 0, out_empty_o 1, out_full_o 0, out_nak_o 0.

Structure
REQ-021 State encodings and the ceil_log2 function SHALL be in the shared usb_cdc package.
REQ-022 Storage and pointers SHALL be inline; no sub-module.

Verification
REQ-023 Packet 0x11,0x22,0x33 then out_ready_i -> app reads 0x11,0x22,0x33 with valid pulses spaced >= 4 cycles; out_empty_o returns to 1.
REQ-024 3 bytes then out_err_i -> no app_out_valid_o; out_last_q unchanged; next good packet 0xAA reads 0xAA only.
REQ-025 Two good 8-byte packets, app stalled -> third out_req_i enters ST_NAK, out_nak_o=1, its bytes never stored.
REQ-026 Pointers wrap: 5 packets of 8 bytes with concurrent reads -> 40 bytes out in order across index 16->0.
REQ-027 rstn_i low mid-packet after 4 bytes -> all outputs at reset values; the next packet is read back intact.
REQ-028 out_valid_i and out_ready_i on the same cycle for last byte 0x7E -> 0x7E delivered as final byte.
